piggy_tx_sequencer: RTL and testbench
=====================================

# piggy_tx_sequencer

Controller between the debounced coin/send pulses and the UART transmitter of the piggy bank. Accumulates the inserted value in baht (coins of 10, 5, 2 and 1), and on a send request snapshots the total. It then converts the snapshot to four ASCII decimal digits and feeds them byte-by-byte to the UART through a valid/ready handshake. After a successful send it optionally clears the transmitted amount.

## Interface
- `MAX_TOTAL`, 9999: saturation ceiling of the accumulator. Must be ≤ 9999; the output is always 4 digits.
- `CLR_ON_SEND`, 1: 1 = subtract the transmitted snapshot from the total after the last byte; 0 = keep the total.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `coin10`, `coin5`, `coin2`, `coin1` in 1 each: single-cycle pulses from the debounce/edge stage.
- `send_req` in 1: single-cycle pulse requesting transmission.
- `tx_ready` in 1: UART can accept a byte this cycle.
- `tx_valid` out 1: byte on `tx_data` is valid.
- `tx_data` out 8: ASCII byte.
- `total` out 14: current accumulated value, binary.
- `busy` out 1: high in every state except IDLE.
- `overflow` out 1: sticky saturation flag.

## Operation
- Reset values: `total`=0, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `overflow`=0, state IDLE.
- Accumulation happens every cycle, in all states.
  - Increment = 10·coin10 + 5·coin5 + 2·coin2 + 1·coin1. Simultaneous pulses are summed (max 18).
  - If total + increment > MAX_TOTAL: total := MAX_TOTAL and overflow := 1.
- FSM states: IDLE, CONV, SEND, DONE.
  - IDLE → CONV on `send_req`.
    - snap := total, loaded into a 14-bit shift register; BCD register := 0; bit counter := 0.
    - `send_req` in any other state is ignored (not queued).
  - CONV: sequential double-dabble, one bit per cycle, 14 cycles total.
    - Each cycle, every BCD nibble ≥ 5 gets +3, then {bcd, shift} shifts left by 1.
    - After 14 cycles → SEND with idx := 0.
  - SEND: `tx_valid`=1; `tx_data` = 8'h30 + BCD digit[3-idx], most-significant digit first.
    - Leading zeros are transmitted.
    - A byte transfers when `tx_valid && tx_ready` on a rising edge. On transfer, idx increments; `tx_data` is stable while waiting.
    - After the final byte → DONE.
  - DONE: lasts one cycle; `tx_valid`=0.
    - If CLR_ON_SEND=1: total := total − snap + increment. Coins arriving during the send are preserved, and saturation still applies.
    - overflow := 0.
    - → IDLE.
- A coin pulse in the DONE cycle is included in the increment term; it is never lost.
- Asserting `rst_n` low mid-operation: all state and outputs go to reset values immediately. Any partial byte stream is abandoned.

## Timing
- `send_req` sampled high in IDLE at edge N:
  - `busy`=1 from N+.
  - CONV occupies cycles N+1..N+14.
  - `tx_valid`=1 with the first digit from edge N+14 (cycle N+15).
- Zero-wait UART (`tx_ready` held 1): one byte per cycle, 4 bytes (6 with CRLF).
  - DONE is the cycle after the last transfer.
  - `busy` falls one cycle after DONE.
  - Total latency from `send_req` to `busy` low = 14 + bytes + 2 cycles.
- `total` updates on the edge following a coin pulse: 1-cycle latency.
- `tx_valid` never drops without a transfer, except on reset.

## Configuration
- `PIGGY_TX_CRLF_EN` defined: after the four digits, two more bytes are sent, 8'h0D then 8'h0A, under the same handshake. That is 6 bytes per send.
- Undefined: exactly 4 bytes per send; DONE follows the least-significant digit.

## Test plan
- Reset, then pulse coin10, coin5, coin2, coin1 in separate cycles, then `send_req` with `tx_ready`=1.
  - → `total`=18.
  - Bytes 0x30,0x30,0x31,0x38 (+0x0D,0x0A with CRLF_EN).
  - First `tx_valid` 15 cycles after `send_req`.
  - `total`=0 after DONE (CLR_ON_SEND=1).
- All four coins in one cycle → `total` increases by 18 in one edge.
- Pre-load 9995, pulse coin10 → `total`=9999, `overflow`=1. Send → "9999". `overflow`=0 after DONE.
- `tx_ready` low for 20 cycles during digit 2 → `tx_valid` stays 1 and `tx_data` stays stable. Transfer resumes when ready; no byte is duplicated or skipped.
- `total`=18, send; coin5 pulse during SEND and another `send_req` during CONV.
  - → transmitted "0018", second request ignored.
  - Final `total`=5.
- `rst_n` low in the middle of SEND → `tx_valid`=0, `busy`=0, `total`=0 immediately. A new send after release transmits "0000".

Source files
------------

// File: rtl/piggy_tx_sequencer.sv
// piggy_tx_sequencer
//   Coin accumulator and ASCII-decimal transmit sequencer for the piggy bank.
//   Coins (10/5/2/1 baht) are summed into a saturating total every cycle. A
//   send request snapshots the total, converts it to BCD with a bit-serial
//   double-dabble (14 cycles), and hands four ASCII digits, most significant
//   first, to the UART over a valid/ready handshake. The handshake is
//   optionally followed by CR LF. The transmitted amount is then optionally
//   removed from the total.
//
//   Build option: define PIGGY_TX_CRLF_EN to append 8'h0D, 8'h0A after the
//   digits (6 bytes per send instead of 4).
//
// Parameters
//   MAX_TOTAL    saturation ceiling of the accumulator (<= 9999)
//   CLR_ON_SEND  1: subtract the sent snapshot from the total in DONE
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   coin10, coin5, coin2, coin1     single-cycle coin pulses
//   send_req                        single-cycle send request (IDLE only)
//   tx_ready                        UART accepts a byte this cycle
//   tx_valid, tx_data[7:0]          byte offered to the UART
//   total[13:0]                     current accumulated value
//   busy                            high whenever not IDLE
//   overflow                        sticky saturation flag, cleared in DONE
module piggy_tx_sequencer #(
   parameter int unsigned MAX_TOTAL   = 9999,
   parameter bit          CLR_ON_SEND = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        coin10,
   input  logic        coin5,
   input  logic        coin2,
   input  logic        coin1,
   input  logic        send_req,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic [13:0] total,
   output logic        busy,
   output logic        overflow
);

`ifdef PIGGY_TX_CRLF_EN
   localparam int unsigned NBYTES = 6;
`else
   localparam int unsigned NBYTES = 4;
`endif
   localparam logic [2:0]  LAST_IDX = 3'(NBYTES - 1);
   localparam logic [14:0] MAX_W    = 15'(MAX_TOTAL);

   typedef enum logic [1:0] {IDLE, CONV, SEND, DONE} state_t;

   state_t      state, state_nx;
   logic [13:0] total_q, snap_q, shift_q;
   logic [15:0] bcd_q, bcd_adj;
   logic [3:0]  bit_cnt;
   logic [2:0]  idx;
   logic        ovf_q;

   logic [4:0]  inc;
   logic [14:0] base, sum;
   logic        sat;
   logic [13:0] total_nx;

   // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
   function automatic logic [15:0] dd_adj(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++)
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      return r;
   endfunction

   assign bcd_adj = dd_adj(bcd_q);

   // Accumulator. total never drops below snap while busy (it only grows or
   // saturates), so the DONE subtraction cannot underflow.
   always_comb begin
      inc = 5'd0;
      if (coin10) inc = inc + 5'd10;
      if (coin5)  inc = inc + 5'd5;
      if (coin2)  inc = inc + 5'd2;
      if (coin1)  inc = inc + 5'd1;
      if (CLR_ON_SEND && state == DONE) base = {1'b0, total_q} - {1'b0, snap_q};
      else                              base = {1'b0, total_q};
      sum      = base + {10'd0, inc};
      sat      = sum > MAX_W;
      total_nx = sat ? MAX_W[13:0] : sum[13:0];
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (send_req) state_nx = CONV;
         CONV:    if (bit_cnt == 4'd13) state_nx = SEND;
         SEND:    if (tx_ready && idx == LAST_IDX) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decode straight from registers, so tx_data holds steady while
   // the UART stalls.
   always_comb begin
      tx_data = 8'h00;
      if (state == SEND) begin
         case (idx)
            3'd0:    tx_data = 8'h30 + {4'h0, bcd_q[15:12]};
            3'd1:    tx_data = 8'h30 + {4'h0, bcd_q[11:8]};
            3'd2:    tx_data = 8'h30 + {4'h0, bcd_q[7:4]};
            3'd3:    tx_data = 8'h30 + {4'h0, bcd_q[3:0]};
            3'd4:    tx_data = 8'h0D;
            3'd5:    tx_data = 8'h0A;
            default: tx_data = 8'h00;
         endcase
      end
   end

   assign tx_valid = (state == SEND);
   assign busy     = (state != IDLE);
   assign total    = total_q;
   assign overflow = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_q <= '0;
         ovf_q   <= 1'b0;
         snap_q  <= '0;
         shift_q <= '0;
         bcd_q   <= '0;
         bit_cnt <= '0;
         idx     <= '0;
      end else begin
         total_q <= total_nx;
         if (state == DONE) ovf_q <= 1'b0;
         else if (sat)      ovf_q <= 1'b1;
         case (state)
            IDLE: if (send_req) begin
               snap_q  <= total_q;
               shift_q <= total_q;
               bcd_q   <= '0;
               bit_cnt <= '0;
            end
            CONV: begin
               // {bcd, shift} <<= 1 after correction
               bcd_q   <= {bcd_adj[14:0], shift_q[13]};
               shift_q <= {shift_q[12:0], 1'b0};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd13) idx <= '0;
            end
            SEND: if (tx_ready) idx <= idx + 3'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_piggy_tx_sequencer.sv
module tb_piggy_tx_sequencer;

`ifdef PIGGY_TX_CRLF_EN
   localparam int NB = 6;
`else
   localparam int NB = 4;
`endif
   localparam int MAXT = 9999;
   localparam bit CLR  = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        coin10 = 0, coin5 = 0, coin2 = 0, coin1 = 0;
   logic        send_req = 0, tx_ready = 0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic [13:0] total;
   logic        busy, overflow;

   piggy_tx_sequencer #(.MAX_TOTAL(MAXT), .CLR_ON_SEND(CLR)) dut (
      .clk(clk), .rst_n(rst_n),
      .coin10(coin10), .coin5(coin5), .coin2(coin2), .coin1(coin1),
      .send_req(send_req), .tx_ready(tx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data),
      .total(total), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference model state (value after the most recent rising edge).
   int         n_cmp = 0, n_fail = 0, cyc = 0;
   int         m_total = 0, m_snap = 0, first_exp = 0, busy_cyc = 0;
   bit         m_ovf = 0, m_busy = 0, m_in_done = 0, seen_first = 0, prev_wait = 0;
   logic [7:0] q[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor + model: runs on the falling edge, checks what the DUT shows
   // after the last rising edge, then predicts the next one from the inputs.
   always @(negedge clk) begin
      int  inc, nt;
      bit  xfer, busy_now;
      cyc++;
      if (!rst_n) begin
         chk("rst_total", int'(total), 0);
         chk("rst_tx_valid", int'(tx_valid), 0);
         chk("rst_tx_data", int'(tx_data), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_overflow", int'(overflow), 0);
         q.delete();
         m_total = 0; m_ovf = 0; m_busy = 0; m_in_done = 0;
         seen_first = 0; prev_wait = 0; busy_cyc = 0;
      end else begin
         chk("total", int'(total), m_total);
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("busy", int'(busy), int'(m_busy));
         xfer = 0;
         if (q.size() == 0) begin
            chk("tx_valid_nothing_pending", int'(tx_valid), 0);
         end else if (tx_valid) begin
            if (!seen_first) begin
               chk("first_valid_latency", cyc, first_exp);
               seen_first = 1;
            end
            chk("tx_data", int'(tx_data), int'(q[0]));
            xfer = tx_ready;
         end else if (seen_first || prev_wait) begin
            chk("tx_valid_dropped", int'(tx_valid), 1);
         end else if (cyc >= first_exp) begin
            chk("first_valid_latency", cyc, first_exp);
            seen_first = 1;
         end
         prev_wait = tx_valid && !tx_ready;

         inc = (coin10 ? 10 : 0) + (coin5 ? 5 : 0) + (coin2 ? 2 : 0) + (coin1 ? 1 : 0);
         busy_now = m_busy;
         if (m_in_done) begin
            nt = (CLR ? m_total - m_snap : m_total) + inc;
            if (nt > MAXT) nt = MAXT;
            m_ovf = 0;
            m_busy = 0;
            m_in_done = 0;
         end else begin
            nt = m_total + inc;
            if (nt > MAXT) begin nt = MAXT; m_ovf = 1; end
         end
         if (xfer) begin
            void'(q.pop_front());
            if (q.size() == 0) m_in_done = 1;
         end
         if (send_req && !busy_now) begin
            m_busy = 1;
            m_snap = m_total;
            q.push_back(8'(8'h30 + (m_snap / 1000) % 10));
            q.push_back(8'(8'h30 + (m_snap / 100) % 10));
            q.push_back(8'(8'h30 + (m_snap / 10) % 10));
            q.push_back(8'(8'h30 + m_snap % 10));
            if (NB == 6) begin q.push_back(8'h0D); q.push_back(8'h0A); end
            first_exp = cyc + 15;
            seen_first = 0;
         end
         m_total = nt;

         busy_cyc = m_busy ? busy_cyc + 1 : 0;
         if (busy_cyc == 700) begin
            n_cmp++; n_fail++;
            $display("FAIL watchdog: busy for %0d cycles, required at most 700", busy_cyc);
         end
      end
   end

   task automatic tick(input logic [3:0] c, input logic s, input logic r);
      {coin10, coin5, coin2, coin1} = c;
      send_req = s;
      tx_ready = r;
      @(posedge clk); #1;
      {coin10, coin5, coin2, coin1} = 4'b0;
      send_req = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500 && (m_busy || q.size() != 0); i++) tick(4'b0, 1'b0, 1'b1);
      tick(4'b0, 1'b0, 1'b1);
   endtask

   task automatic load_to(input int tgt);
      int r;
      r = tgt - m_total;
      while (r >= 18) begin tick(4'b1111, 1'b0, 1'b1); r -= 18; end
      if (r >= 10) begin tick(4'b1000, 1'b0, 1'b1); r -= 10; end
      if (r >= 5)  begin tick(4'b0100, 1'b0, 1'b1); r -= 5; end
      while (r >= 2) begin tick(4'b0010, 1'b0, 1'b1); r -= 2; end
      if (r >= 1)  begin tick(4'b0001, 1'b0, 1'b1); r -= 1; end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Separate coins, then send with a zero-wait UART: "0018", total -> 0.
      tick(4'b1000, 0, 1); tick(4'b0100, 0, 1); tick(4'b0010, 0, 1); tick(4'b0001, 0, 1);
      tick(4'b0000, 1, 1);
      wait_idle();

      // All four coins in one cycle (+18), then saturate from 9995 with coin10.
      tick(4'b1111, 0, 1);
      load_to(9995);
      tick(4'b1000, 0, 1);
      tick(4'b0000, 1, 1);
      wait_idle();

      // UART stall for 20 cycles while the third byte is on offer.
      tick(4'b1111, 0, 1); tick(4'b1111, 0, 1); tick(4'b1111, 0, 1);
      tick(4'b0000, 1, 1);
      for (int i = 0; i < 100 && q.size() != NB - 2; i++) tick(4'b0, 0, 1);
      repeat (20) tick(4'b0, 0, 0);
      wait_idle();

      // Second request during CONV is ignored; coin5 during SEND survives.
      tick(4'b1111, 0, 1);
      tick(4'b0000, 1, 0);
      repeat (5) tick(4'b0, 0, 0);
      tick(4'b0000, 1, 0);
      repeat (10) tick(4'b0, 0, 0);
      tick(4'b0100, 0, 0);
      wait_idle();

      // Reset in the middle of SEND, then a fresh send transmits "0000".
      tick(4'b0000, 1, 1);
      repeat (16) tick(4'b0, 0, 1);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick(4'b0000, 1, 1);
      wait_idle();

      // Random traffic: sparse coins, occasional requests, flaky UART.
      for (int i = 0; i < 600; i++) begin
         logic [3:0] c;
         for (int b = 0; b < 4; b++) c[b] = ($urandom_range(0, 7) == 0);
         tick(c, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
      end
      wait_idle();
      repeat (3) tick(4'b0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
